// File: rtl/sad_mode_select_stream.sv
// Streaming intra-mode decision: per-candidate SAD over LANES-wide residual beats, best residual
// kept in a ping-pong buffer and replayed. Optional `SAD_COST_BIAS_EN adds an MPM signalling penalty.
module sad_mode_select_stream #(
    parameter int NUM_MODES = 9,
    parameter int SAMPLES   = 16,
    parameter int LANES     = 4,
    parameter int RES_W     = 9,
    parameter int BIAS      = 4,
    localparam int MW       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int SAD_W    = RES_W + $clog2(SAMPLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MW-1:0]          in_mode,
    input  logic [LANES*RES_W-1:0] in_res,
    input  logic                   in_mode_last,
    input  logic [MW-1:0]          mpm_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MW-1:0]          out_mode,
    output logic [SAD_W-1:0]       out_cost,
    output logic [LANES*RES_W-1:0] out_res,
    output logic                   out_last
);

    localparam int BEATS = SAMPLES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(NUM_MODES + 1);
    localparam int DW    = LANES * RES_W;

    // state  | meaning
    // IDLE   | waiting for the first beat of a block
    // ACCUM  | accumulating candidate SADs, tracking the running best
    // OUTPUT | replaying the best residual, input stalled
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]     out_cnt_q, out_cnt_d;
    logic [CW-1:0]     cand_cnt_q, cand_cnt_d;
    logic [SAD_W-1:0]  acc_q, acc_d;
    logic [SAD_W-1:0]  best_cost_q, best_cost_d;
    logic [MW-1:0]     best_mode_q, best_mode_d;
    logic              best_bank_q, best_bank_d;

    logic [DW-1:0]     bank_q [2][BEATS];

    logic              accept;
    logic              final_beat;
    logic              new_best;
    logic              wr_en;
    logic [SAD_W-1:0]  beat_sad;
    logic [SAD_W-1:0]  sad_total;
    logic [SAD_W-1:0]  cand_cost;

    assign in_ready   = ~reset & (state_q != OUTPUT);
    assign accept     = in_valid & in_ready;
    assign final_beat = (beat_cnt_q == BW'(BEATS - 1));

    // One extra bit on the magnitude so the most negative residual maps to its exact absolute value.
    always_comb begin
        logic [RES_W:0] lane_ext;
        logic [RES_W:0] lane_abs;
        beat_sad = '0;
        lane_ext = '0;
        lane_abs = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_ext = {in_res[l*RES_W + RES_W - 1], in_res[l*RES_W +: RES_W]};
            lane_abs = lane_ext[RES_W] ? -lane_ext : lane_ext;
            beat_sad = beat_sad + SAD_W'(lane_abs);
        end
    end

    assign sad_total = acc_q + beat_sad;

`ifdef SAD_COST_BIAS_EN
    logic [SAD_W:0] cost_ext;

    always_comb begin
        cost_ext  = {1'b0, sad_total} + ((in_mode != mpm_mode) ? (SAD_W+1)'(BIAS) : '0);
        cand_cost = cost_ext[SAD_W] ? {SAD_W{1'b1}} : cost_ext[SAD_W-1:0];
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{mpm_mode, BIAS};
    assign cand_cost  = sad_total;
`endif

    // Ties resolve towards the lower mode id, independent of arrival order.
    assign new_best = (cand_cnt_q == '0)
                    || (cand_cost < best_cost_q)
                    || ((cand_cost == best_cost_q) && (in_mode < best_mode_q));

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        out_cnt_d   = out_cnt_q;
        cand_cnt_d  = cand_cnt_q;
        acc_d       = acc_q;
        best_cost_d = best_cost_q;
        best_mode_d = best_mode_q;
        best_bank_d = best_bank_q;
        wr_en       = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    state_d = ACCUM;
                    if (final_beat) begin
                        beat_cnt_d = '0;
                        acc_d      = '0;
                        if (cand_cnt_q != CW'(NUM_MODES)) begin
                            cand_cnt_d = cand_cnt_q + CW'(1);
                        end
                        if (new_best) begin
                            best_cost_d = cand_cost;
                            best_mode_d = in_mode;
                            best_bank_d = ~best_bank_q;
                        end
                        if (in_mode_last) begin
                            state_d    = OUTPUT;
                            cand_cnt_d = '0;
                            out_cnt_d  = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                        acc_d      = sad_total;
                    end
                end
            end

            OUTPUT: begin
                if (out_ready) begin
                    if (out_cnt_q == BW'(BEATS - 1)) begin
                        out_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + BW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            out_cnt_q   <= '0;
            cand_cnt_q  <= '0;
            acc_q       <= '0;
            best_cost_q <= '0;
            best_mode_q <= '0;
            best_bank_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            out_cnt_q   <= out_cnt_d;
            cand_cnt_q  <= cand_cnt_d;
            acc_q       <= acc_d;
            best_cost_q <= best_cost_d;
            best_mode_q <= best_mode_d;
            best_bank_q <= best_bank_d;
        end
    end

    // The candidate under test always lands in the bank not holding the current best.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[~best_bank_q][beat_cnt_q] <= in_res;
        end
    end

    assign out_valid = (state_q == OUTPUT);
    assign out_last  = out_valid && (out_cnt_q == BW'(BEATS - 1));
    assign out_mode  = best_mode_q;
    assign out_cost  = best_cost_q;
    assign out_res   = out_valid ? bank_q[best_bank_q][out_cnt_q] : '0;

endmodule

// File: tb/tb_sad_mode_select_stream.sv
// Self-checking bench for sad_mode_select_stream: directed cases plus randomized blocks with
// input gaps and output backpressure, checked against a per-block reference model.
module tb_sad_mode_select_stream;

    localparam int NUM_MODES = 9;
    localparam int SAMPLES   = 16;
    localparam int LANES     = 4;
    localparam int RES_W     = 9;
    localparam int BIAS      = 4;
    localparam int MW        = 4;
    localparam int SAD_W     = 13;
    localparam int BEATS     = SAMPLES / LANES;
    localparam int DW        = LANES * RES_W;
    localparam int MAXC      = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [MW-1:0]     in_mode;
    logic [DW-1:0]     in_res;
    logic              in_mode_last;
    logic [MW-1:0]     mpm_mode;
    logic              out_valid;
    logic              out_ready;
    logic [MW-1:0]     out_mode;
    logic [SAD_W-1:0]  out_cost;
    logic [DW-1:0]     out_res;
    logic              out_last;

    int cand_res [MAXC][SAMPLES];
    int cand_mode [MAXC];
    int n_cand;
    int mpm;
    int n_chk  = 0;
    int n_fail = 0;
    logic [MW-1:0]    obs_mode;
    logic [SAD_W-1:0] obs_cost;

    sad_mode_select_stream #(
        .NUM_MODES (NUM_MODES),
        .SAMPLES   (SAMPLES),
        .LANES     (LANES),
        .RES_W     (RES_W),
        .BIAS      (BIAS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_res       (in_res),
        .in_mode_last (in_mode_last),
        .mpm_mode     (mpm_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_cost     (out_cost),
        .out_res      (out_res),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int c, input int b);
        logic [31:0]   tmp;
        logic [DW-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) begin
            tmp = cand_res[c][b*LANES + l];
            w[l*RES_W +: RES_W] = tmp[RES_W-1:0];
        end
        return w;
    endfunction

    // Whole-block reference: SAD per candidate, optional bias, lowest cost then lowest mode wins.
    task automatic model(output int bm, output int bc, output int bi);
        int sad;
        int cost;
        bm = 0;
        bc = 0;
        bi = 0;
        for (int c = 0; c < n_cand; c++) begin
            sad = 0;
            for (int s = 0; s < SAMPLES; s++) begin
                sad += (cand_res[c][s] < 0) ? -cand_res[c][s] : cand_res[c][s];
            end
            cost = sad;
`ifdef SAD_COST_BIAS_EN
            if (cand_mode[c] != mpm) cost += BIAS;
            if (cost > (1 << SAD_W) - 1) cost = (1 << SAD_W) - 1;
`endif
            if (c == 0 || cost < bc || (cost == bc && cand_mode[c] < bm)) begin
                bm = cand_mode[c];
                bc = cost;
                bi = c;
            end
        end
    endtask

    task automatic fill_rand(input int c, input int kind);
        for (int s = 0; s < SAMPLES; s++) begin
            case (kind)
                0:       cand_res[c][s] = int'($urandom_range(0, 511)) - 256;
                1:       cand_res[c][s] = int'($urandom_range(0, 6)) - 3;
                default: cand_res[c][s] = ($urandom_range(0, 1) == 1) ? -256 : 255;
            endcase
        end
    endtask

    task automatic send_beat(input int c, input int b, input bit gaps);
        int t;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_res   = DW'({$urandom, $urandom});
                @(posedge clk);
                #1;
            end
        end
        in_valid     = 1'b1;
        in_res       = exp_word(c, b);
        in_mode      = MW'(cand_mode[c]);
        in_mode_last = (b == BEATS - 1) ? (c == n_cand - 1) : 1'($urandom_range(0, 1));
        mpm_mode     = MW'(mpm);
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready_accum", in_ready, 1'b1);
        chk("no_out_during_accum", out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_mode_last = 1'b0;
    endtask

    task automatic run_block(input bit bp, input bit gaps);
        int bm, bc, bi;
        int b, t;
        for (int c = 0; c < n_cand; c++) begin
            for (int k = 0; k < BEATS; k++) send_beat(c, k, gaps);
        end
        model(bm, bc, bi);
        chk("latency_out_valid", out_valid, 1'b1);
        b = 0;
        t = 0;
        while (b < BEATS && t < 200) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (gaps) in_valid = 1'($urandom_range(0, 1));
            chk("out_valid", out_valid, 1'b1);
            chk("in_ready_output", in_ready, 1'b0);
            chk("out_mode", out_mode, bm);
            chk("out_cost", out_cost, bc);
            chk($sformatf("out_res_b%0d", b), out_res, exp_word(bi, b));
            chk($sformatf("out_last_b%0d", b), out_last, (b == BEATS - 1));
            obs_mode = out_mode;
            obs_cost = out_cost;
            @(posedge clk);
            #1;
            if (out_ready) b++;
            t++;
            out_ready = 1'b0;
            in_valid  = 1'b0;
        end
        chk("out_beats_done", b, BEATS);
        chk("out_valid_after", out_valid, 1'b0);
        chk("in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        int bm, bc, bi;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_res       = '0;
        in_mode      = '0;
        in_mode_last = 1'b0;
        mpm_mode     = '0;
        out_ready    = 1'b0;
        mpm          = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_cost", out_cost, 0);
        chk("rst_out_res", out_res, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1'b1);

        // Abort: one full candidate plus two beats of the next, then reset.
        n_cand       = 2;
        cand_mode[0] = 3;
        cand_mode[1] = 6;
        for (int s = 0; s < SAMPLES; s++) cand_res[0][s] = s + 1;
        fill_rand(1, 0);
        for (int k = 0; k < BEATS; k++) send_beat(0, k, 1'b0);
        send_beat(1, 0, 1'b0);
        send_beat(1, 1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_mode", out_mode, 0);
        chk("abort_out_cost", out_cost, 0);
        chk("abort_out_res", out_res, 0);
        chk("abort_out_last", out_last, 1'b0);

        // Nine candidates, mode 5 cheapest.
        n_cand = 9;
        mpm    = 5;
        for (int c = 0; c < 9; c++) begin
            cand_mode[c] = c;
            for (int s = 0; s < SAMPLES; s++) cand_res[c][s] = (c == 5) ? 1 : 3;
        end
        run_block(1'b0, 1'b0);
        chk("nine_mode", obs_mode, 5);
        chk("nine_cost", obs_cost, 16);

        // Ties at SAD 40 in both arrival orders.
        for (int o = 0; o < 2; o++) begin
            n_cand = 2;
            mpm    = 0;
            cand_mode[0] = (o == 0) ? 7 : 2;
            cand_mode[1] = (o == 0) ? 2 : 7;
            for (int c = 0; c < 2; c++) begin
                for (int s = 0; s < SAMPLES; s++) begin
                    if (cand_mode[c] == 7) cand_res[c][s] = (s < 8) ? -2 : 3;
                    else                   cand_res[c][s] = (s < 8) ? 3 : -2;
                end
            end
            run_block(1'b0, 1'b0);
            chk($sformatf("tie_mode_o%0d", o), obs_mode, 2);
        end

        // Most negative residual everywhere.
        n_cand       = 1;
        mpm          = 4;
        cand_mode[0] = 4;
        for (int s = 0; s < SAMPLES; s++) cand_res[0][s] = -256;
        run_block(1'b1, 1'b0);
        chk("extreme_cost", obs_cost, 4096);
        chk("extreme_mode", obs_mode, 4);

        // MPM bias case.
        n_cand       = 2;
        mpm          = 1;
        cand_mode[0] = 0;
        cand_mode[1] = 1;
        for (int s = 0; s < SAMPLES; s++) begin
            cand_res[0][s] = (s < 12) ? 1 : 2;
            cand_res[1][s] = (s < 10) ? -1 : 2;
        end
        run_block(1'b0, 1'b0);
`ifdef SAD_COST_BIAS_EN
        chk("bias_mode", obs_mode, 1);
        chk("bias_cost", obs_cost, 22);
`else
        chk("bias_mode", obs_mode, 0);
        chk("bias_cost", obs_cost, 20);
`endif

        // Random blocks with input gaps and output backpressure, including oversize blocks.
        for (int it = 0; it < 25; it++) begin
            n_cand = $urandom_range(1, 12);
            mpm    = $urandom_range(0, NUM_MODES - 1);
            for (int c = 0; c < n_cand; c++) begin
                cand_mode[c] = $urandom_range(0, NUM_MODES - 1);
                fill_rand(c, $urandom_range(0, 2));
            end
            run_block(1'b1, 1'b1);
            model(bm, bc, bi);
            chk($sformatf("rand%0d_mode", it), obs_mode, bm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
